wb_axi4lite_bridge: RTL
=======================

Name: wb_axi4lite_bridge

Overview:
Parametrised pipelined-Wishbone slave to AXI4-lite master bridge. It is the next generation of the generated single-submap WB→AXI4-lite interface. Additions over that generation:
- configurable address/data width and AXI protection bits;
- true bready/rready handshaking with independent AW/W acceptance;
- AXI error responses propagated to wb_err_o;
- a transaction timeout with safe AXI draining.

It sits between a WB crossbar port and one AXI4-lite register block.

Parameters:
ADDR_WIDTH, 12, byte-address width of AXI side; WB word address is [ADDR_WIDTH-1:DATA_WIDTH/32+1]
DATA_WIDTH, 32, 32 or 64; bus data width
PROT, 3'b000, constant driven on awprot/arprot
TIMEOUT, 255, cycles from request acceptance to forced error; 0 disables timeout

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  asynchronous active-high reset
wb_cyc_i  in  1  WB cycle
wb_stb_i  in  1  WB strobe
wb_adr_i  in  ADDR_WIDTH-LSB  WB word address (LSB = log2(DATA_WIDTH/8))
wb_sel_i  in  DATA_WIDTH/8  byte selects
wb_we_i  in  1  write enable
wb_dat_i  in  DATA_WIDTH  write data
wb_ack_o  out  1  completion, OK response
wb_err_o  out  1  completion, error (SLVERR/DECERR/timeout)
wb_rty_o  out  1  tied 0
wb_stall_o  out  1  stall
wb_dat_o  out  DATA_WIDTH  read data
m_awvalid_o/m_awready_i  out/in  1  AW handshake
m_awaddr_o  out  ADDR_WIDTH  write address, low LSB bits 0
m_awprot_o  out  3  = PROT
m_wvalid_o/m_wready_i  out/in  1  W handshake
m_wdata_o  out  DATA_WIDTH  write data
m_wstrb_o  out  DATA_WIDTH/8  = latched wb_sel_i
m_bvalid_i/m_bready_o  in/out  1  B handshake
m_bresp_i  in  2  write response
m_arvalid_o/m_arready_i  out/in  1  AR handshake
m_araddr_o  out  ADDR_WIDTH  read address
m_arprot_o  out  3  = PROT
m_rvalid_i/m_rready_o  in/out  1  R handshake
m_rdata_i  in  DATA_WIDTH  read data
m_rresp_i  in  2  read response

Behaviour:
- Reset state: all outputs 0, wb_dat_o 0, FSM in IDLE, timeout counter 0.
- wb_stall_o = wb_cyc_i & wb_stb_i & (state != IDLE). A request is accepted only in IDLE (one per cycle max, one outstanding).
- Acceptance: address, data and sel are latched into registers, which drive the AXI address/data/strb outputs. Counter is loaded with TIMEOUT.
- FSM states: IDLE, WR, WR_RESP, RD, RD_RESP, DRAIN.
- IDLE, write accepted → WR with aw_pend=w_pend=1. Read accepted → RD with ar_pend=1.
- WR:
  - awvalid=aw_pend, wvalid=w_pend.
  - Each pend clears on its ready; the two may clear in any order or in the same cycle.
  - When both are clear (or clear this cycle) → WR_RESP.
- WR_RESP: bready=1. On bvalid:
  - ack for bresp[1]=0, err for bresp[1]=1;
  - → IDLE.
- RD: arvalid=1; on arready → RD_RESP.
- RD_RESP: rready=1. On rvalid:
  - latch rdata into wb_dat_o (also on error);
  - ack/err per rresp[1];
  - → IDLE.
- Completion timing: ack/err are registered one-cycle pulses, asserted the cycle after the B/R handshake. Exactly one of ack/err per request.
- Minimum latency (ready/valid always high):
  - write: accept cycle T; AW/W valid T+1; bready T+2; ack T+3;
  - read: same schedule.
- Timeout (TIMEOUT>0):
  - counter decrements each cycle in WR/WR_RESP/RD/RD_RESP;
  - on reaching 0, pulse wb_err_o and → DRAIN.
- DRAIN:
  - keeps asserting any still-pending valid until accepted (AXI never retracts valid);
  - bready/rready=1; the response is discarded;
  - → IDLE after response handshake.
  - stall stays high throughout.
- Timeout and response in the same cycle: the response wins (normal ack/err), no timeout error.
- wb_cyc_i dropped mid-transaction: the AXI transaction still completes normally. ack/err is still pulsed (masters ignore it).
- Asynchronous reset mid-transaction: immediate return to reset values; responsibility for the slave lies with system reset.

Decomposition:
- Package wb_axi4lite_pkg:
  - state enum;
  - AXI resp constants OKAY/EXOKAY/SLVERR/DECERR;
  - function is_err(resp) = resp[1].
- One natural sub-module: bridge_timeout_cnt (load, enable, expired), width $clog2(TIMEOUT+1).

Test Plan:
- Write 0xDEADBEEF to adr 0x10, sel 0xF, all readies high → awaddr=0x10, wstrb=0xF, wdata matches; ack 3 cycles after acceptance; err=0.
- Write with awready delayed 4 cycles and wready immediate, then reversed; also both in the same cycle → each valid drops only after its ready; single ack.
- Read adr 0x20, slave returns rdata=0x12345678, rresp=OKAY after 2-cycle rvalid delay → wb_dat_o=0x12345678 with ack; stall high until then.
- Read with rresp=SLVERR, and write with bresp=DECERR → wb_err_o pulse, no ack.
- TIMEOUT=8, slave never asserts arready → err at cycle 9 after accept. arvalid stays high; when arready then rvalid arrive, no WB pulse; the next request is accepted afterwards.
- Back-to-back pipelined requests (stb held) → second stalled until first acks; reset asserted in WR clears all valids the same cycle asynchronously.

Source files
------------

// File: rtl/wb_axi4lite_pkg.sv
// Shared types and AXI response helpers for the Wishbone to AXI4-lite bridge.
package wb_axi4lite_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD      = 3'd3,
    S_RD_RESP = 3'd4,
    S_DRAIN   = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // SLVERR and DECERR are the only responses with bit 1 set.
  function automatic logic is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/bridge_timeout_cnt.sv
// Down-counter that flags the cycle in which an outstanding request runs out of time.
module bridge_timeout_cnt #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic expired_c
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(TIMEOUT);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the decrement that takes the count to zero.
  assign expired_c = (TIMEOUT != 0) && en_i && (cnt_q == CW'(1));

endmodule

// File: rtl/wb_axi4lite_bridge.sv
// Pipelined Wishbone slave to AXI4-lite master bridge, one outstanding request,
// with AXI error propagation and a timeout that drains the AXI side safely.
module wb_axi4lite_bridge
  import wb_axi4lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [2:0]  PROT       = 3'b000,
  parameter int unsigned TIMEOUT    = 255,
  localparam int unsigned LSB       = $clog2(DATA_WIDTH / 8),
  localparam int unsigned SW        = DATA_WIDTH / 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      wb_cyc_i,
  input  logic                      wb_stb_i,
  input  logic [ADDR_WIDTH-1:LSB]   wb_adr_i,
  input  logic [SW-1:0]             wb_sel_i,
  input  logic                      wb_we_i,
  input  logic [DATA_WIDTH-1:0]     wb_dat_i,
  output logic                      wb_ack_o,
  output logic                      wb_err_o,
  output logic                      wb_rty_o,
  output logic                      wb_stall_o,
  output logic [DATA_WIDTH-1:0]     wb_dat_o,
  output logic                      m_awvalid_o,
  input  logic                      m_awready_i,
  output logic [ADDR_WIDTH-1:0]     m_awaddr_o,
  output logic [2:0]                m_awprot_o,
  output logic                      m_wvalid_o,
  input  logic                      m_wready_i,
  output logic [DATA_WIDTH-1:0]     m_wdata_o,
  output logic [SW-1:0]             m_wstrb_o,
  input  logic                      m_bvalid_i,
  output logic                      m_bready_o,
  input  logic [1:0]                m_bresp_i,
  output logic                      m_arvalid_o,
  input  logic                      m_arready_i,
  output logic [ADDR_WIDTH-1:0]     m_araddr_o,
  output logic [2:0]                m_arprot_o,
  input  logic                      m_rvalid_i,
  output logic                      m_rready_o,
  input  logic [DATA_WIDTH-1:0]     m_rdata_i,
  input  logic [1:0]                m_rresp_i
);

  state_e state_q, state_d;

  logic                    aw_pend_q, aw_pend_d;
  logic                    w_pend_q,  w_pend_d;
  logic                    ar_pend_q, ar_pend_d;
  logic                    bready_q,  bready_d;
  logic                    rready_q,  rready_d;
  logic                    ack_q,     ack_d;
  logic                    err_q,     err_d;
  logic                    is_wr_q,   is_wr_d;
  logic [ADDR_WIDTH-1:LSB] adr_q,     adr_d;
  logic [DATA_WIDTH-1:0]   wdata_q,   wdata_d;
  logic [SW-1:0]           strb_q,    strb_d;
  logic [DATA_WIDTH-1:0]   rdata_q,   rdata_d;

  logic req_c, busy_c, timeout_c;
  logic aw_done_c, w_done_c, ar_done_c, drain_done_c;

  assign req_c     = wb_cyc_i & wb_stb_i & (state_q == S_IDLE);
  assign busy_c    = (state_q == S_WR) || (state_q == S_WR_RESP) ||
                     (state_q == S_RD) || (state_q == S_RD_RESP);
  assign aw_done_c = ~aw_pend_q | m_awready_i;
  assign w_done_c  = ~w_pend_q  | m_wready_i;
  assign ar_done_c = ~ar_pend_q | m_arready_i;

  // Leave DRAIN only once the response is taken and no valid would be retracted.
  assign drain_done_c = (is_wr_q ? (m_bvalid_i & bready_q) : (m_rvalid_i & rready_q)) &
                        aw_done_c & w_done_c & ar_done_c;

  bridge_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (req_c),
    .en_i      (busy_c),
    .expired_c (timeout_c)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A response arriving in the expiry cycle takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_c) state_d = wb_we_i ? S_WR : S_RD;
      end
      S_WR: begin
        if (timeout_c)                  state_d = S_DRAIN;
        else if (aw_done_c && w_done_c) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (m_bvalid_i)     state_d = S_IDLE;
        else if (timeout_c) state_d = S_DRAIN;
      end
      S_RD: begin
        if (timeout_c)        state_d = S_DRAIN;
        else if (m_arready_i) state_d = S_RD_RESP;
      end
      S_RD_RESP: begin
        if (m_rvalid_i)     state_d = S_IDLE;
        else if (timeout_c) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_done_c) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    aw_pend_d = aw_pend_q & ~m_awready_i;
    w_pend_d  = w_pend_q  & ~m_wready_i;
    ar_pend_d = ar_pend_q & ~m_arready_i;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    is_wr_d   = is_wr_q;
    adr_d     = adr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    rdata_d   = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_c) begin
          is_wr_d   = wb_we_i;
          adr_d     = wb_adr_i;
          wdata_d   = wb_dat_i;
          strb_d    = wb_sel_i;
          aw_pend_d = wb_we_i;
          w_pend_d  = wb_we_i;
          ar_pend_d = ~wb_we_i;
        end
      end
      S_WR, S_RD: begin
        err_d = timeout_c;
      end
      S_WR_RESP: begin
        if (m_bvalid_i) begin
          ack_d = ~is_err(m_bresp_i);
          err_d = is_err(m_bresp_i);
        end else begin
          err_d = timeout_c;
        end
      end
      S_RD_RESP: begin
        if (m_rvalid_i) begin
          rdata_d = m_rdata_i;
          ack_d   = ~is_err(m_rresp_i);
          err_d   = is_err(m_rresp_i);
        end else begin
          err_d = timeout_c;
        end
      end
      default: ;
    endcase
    bready_d = (state_d == S_WR_RESP) || ((state_d == S_DRAIN) && is_wr_d);
    rready_d = (state_d == S_RD_RESP) || ((state_d == S_DRAIN) && !is_wr_d);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      ar_pend_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      is_wr_q   <= 1'b0;
      adr_q     <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      rdata_q   <= '0;
    end else begin
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      ar_pend_q <= ar_pend_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      is_wr_q   <= is_wr_d;
      adr_q     <= adr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      rdata_q   <= rdata_d;
    end
  end

  assign wb_ack_o    = ack_q;
  assign wb_err_o    = err_q;
  assign wb_rty_o    = 1'b0;
  assign wb_stall_o  = wb_cyc_i & wb_stb_i & (state_q != S_IDLE);
  assign wb_dat_o    = rdata_q;
  assign m_awvalid_o = aw_pend_q;
  assign m_awaddr_o  = {adr_q, {LSB{1'b0}}};
  assign m_awprot_o  = PROT;
  assign m_wvalid_o  = w_pend_q;
  assign m_wdata_o   = wdata_q;
  assign m_wstrb_o   = strb_q;
  assign m_bready_o  = bready_q;
  assign m_arvalid_o = ar_pend_q;
  assign m_araddr_o  = {adr_q, {LSB{1'b0}}};
  assign m_arprot_o  = PROT;
  assign m_rready_o  = rready_q;

endmodule
